// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NumReq producers share one FIFO write port.
// A granted multi-beat burst keeps the grant (LOCKED) until its last beat transfers.
module fifo_wr_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         dtype     = logic [DataWidth-1:0],
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  dtype                req_data_i [NumReq],
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  logic                fifo_full_i,
  output logic                fifo_push_o,
  output dtype                fifo_data_o,
  output logic [IdxWidth-1:0] grant_idx_o,
  output logic                grant_valid_o,
  output logic                locked_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

  logic [IdxWidth:0]   scan_sum_s;
  logic [IdxWidth-1:0] scan_cand_s;
  logic [IdxWidth-1:0] scan_idx_s;
  logic                scan_take_s;
  logic                scan_hit_s;
  logic [IdxWidth-1:0] grant_s;
  logic [IdxWidth-1:0] grant_next_s;
  logic                grant_valid_s;
  logic                xfer_s;

  // Round-robin scan starting at rr_ptr_q; the wrap subtracts NumReq so odd sizes never overflow
  always_comb begin
    scan_sum_s  = '0;
    scan_cand_s = '0;
    scan_take_s = 1'b0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan_sum_s  = {1'b0, rr_ptr_q} + (IdxWidth+1)'(i);
      scan_cand_s = (scan_sum_s >= (IdxWidth+1)'(NumReq)) ?
                    IdxWidth'(scan_sum_s - (IdxWidth+1)'(NumReq)) : IdxWidth'(scan_sum_s);
      scan_take_s = !scan_hit_s && req_valid_i[scan_cand_s];
      scan_idx_s  = scan_take_s ? scan_cand_s : scan_idx_s;
      scan_hit_s  = scan_hit_s | scan_take_s;
    end
  end

  // Grant selection, transfer qualification and next-state
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (state_q == LOCKED) begin
      grant_s       = lock_idx_q;
      grant_valid_s = req_valid_i[lock_idx_q];
    end else begin
      grant_s       = scan_idx_s;
      grant_valid_s = scan_hit_s;
    end
    // Reset also gates the handshake so nothing is accepted while rst_i is high
    xfer_s       = grant_valid_s & ~fifo_full_i & ~clr_i & ~rst_i;
    grant_next_s = (grant_s == IdxWidth'(NumReq - 1)) ? '0 : grant_s + IdxWidth'(1);
    if (clr_i) begin
      state_d    = IDLE;
      rr_ptr_d   = '0;
      lock_idx_d = '0;
    end else if (xfer_s) begin
      case (state_q)
        IDLE: begin
          if (req_last_i[grant_s]) begin
            rr_ptr_d = grant_next_s;
          end else begin
            state_d    = LOCKED;
            lock_idx_d = grant_s;
          end
        end
        LOCKED: begin
          if (req_last_i[grant_s]) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next_s;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode, combinational from state and inputs
  always_comb begin
    fifo_push_o   = xfer_s;
    grant_valid_o = grant_valid_s;
    grant_idx_o   = grant_valid_s ? grant_s : '0;
    fifo_data_o   = grant_valid_s ? req_data_i[grant_s] : '0;
    locked_o      = (state_q == LOCKED);
    req_ready_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = xfer_s && (grant_s == IdxWidth'(i));
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
